// File: rtl/qed_dup_feeder_if.sv
// ---------------------------------------------------------------------------
// qed_dup_feeder_if
// Groups the instruction handshake and status signals of the QED duplicate
// feeder into one bundle. The generator side (bench or upstream logic) uses
// the master modport, and the feeder itself uses the slave modport.
//
// Signals:
//   instruction  candidate instruction from the symbolic generator
//   exec_dup     request to leave the original phase and start duplicates
//   stall        pipeline cannot accept an instruction this cycle
//   qed_inst     registered instruction presented to the fetch port
//   qed_valid    qed_inst is a counted original or duplicate, not filler
//   orig_cnt     originals issued so far
//   dup_cnt      duplicates issued so far
//   qed_ready    equal nonzero counts and phase DONE
//   fifo_full    original-instruction buffer is full
//   phase        current phase (0 ORIG, 1 DUP, 2 DONE)
// ---------------------------------------------------------------------------
interface qed_dup_feeder_if #(
   parameter int INSN_LEN = 32,
   parameter int DEPTH    = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [INSN_LEN-1:0] instruction;
   logic                exec_dup;
   logic                stall;
   logic [INSN_LEN-1:0] qed_inst;
   logic                qed_valid;
   logic [CNT_W-1:0]    orig_cnt;
   logic [CNT_W-1:0]    dup_cnt;
   logic                qed_ready;
   logic                fifo_full;
   logic [1:0]          phase;

   // The instruction source drives the request side and watches the status
   modport master (
      output instruction, exec_dup, stall,
      input  qed_inst, qed_valid, orig_cnt, dup_cnt, qed_ready, fifo_full, phase
   );

   // The feeder consumes the request side and drives the status
   modport slave (
      input  instruction, exec_dup, stall,
      output qed_inst, qed_valid, orig_cnt, dup_cnt, qed_ready, fifo_full, phase
   );
endinterface

// File: rtl/qed_dup_feeder.sv
// ---------------------------------------------------------------------------
// qed_dup_feeder
// Feeds a pipeline for QED-style self-consistency checking. In the ORIG phase
// each accepted instruction is issued and remembered in a small buffer. Once
// duplicates are requested, the buffered originals are re-issued in the same
// order with every nonzero register index (rd, rs1, rs2) moved up by
// REG_OFFSET, so the duplicates touch the upper register half only. When the
// buffer drains the block parks in DONE and reports qed_ready if both halves
// saw the same nonzero number of instructions.
//
// Parameters:
//   INSN_LEN    instruction width in bits (field layout assumes >= 32)
//   DEPTH       buffer depth, power of two, >= 2
//   REG_OFFSET  register-index offset applied to duplicates (modulo 32)
//
// Ports:
//   clk         single clock, rising edge
//   reset_x     asynchronous active-low reset
//   feedBus     qed_dup_feeder_if.slave bundle (see interface for signals)
//
// Configuration macro:
//   QED_FORCE_DUP_EN  when defined, a full buffer in ORIG switches to DUP on
//                     its own; otherwise extra instructions are dropped and
//                     the block waits in ORIG for exec_dup.
// ---------------------------------------------------------------------------
module qed_dup_feeder #(
   parameter int INSN_LEN   = 32,
   parameter int DEPTH      = 16,
   parameter int REG_OFFSET = 16
) (
   input  logic clk,
   input  logic reset_x,
   qed_dup_feeder_if.slave feedBus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [INSN_LEN-1:0] NOP = INSN_LEN'(32'h00000013);
   localparam logic [4:0] REG_OFF5 = 5'(REG_OFFSET % 32);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ORIG = 2'd0,
      DUP  = 2'd1,
      DONE = 2'd2
   } phase_t;

   phase_t              phase_q, phase_d;
   logic [INSN_LEN-1:0] qedInst_q, qedInst_d;
   logic                qedValid_q, qedValid_d;
   logic [CNT_W-1:0]    origCnt_q, origCnt_d;
   logic [CNT_W-1:0]    dupCnt_q, dupCnt_d;
   logic [CNT_W-1:0]    fifoCount_q, fifoCount_d;
   logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
   logic                pushEn;
   logic                fifoFull;
   logic                fifoEmpty;

   logic [INSN_LEN-1:0] origMem [DEPTH];

   // Register fields are remapped independently; a zero index means x0 and
   // must stay x0 so the duplicate keeps the same hard-wired-zero semantics.
   function automatic logic [INSN_LEN-1:0] makeDup(input logic [INSN_LEN-1:0] insn);
      logic [INSN_LEN-1:0] dupInsn;
      dupInsn = insn;
      if (insn[11:7] != 5'd0) begin
         dupInsn[11:7] = insn[11:7] + REG_OFF5;
      end
      if (insn[19:15] != 5'd0) begin
         dupInsn[19:15] = insn[19:15] + REG_OFF5;
      end
      if (insn[24:20] != 5'd0) begin
         dupInsn[24:20] = insn[24:20] + REG_OFF5;
      end
      return dupInsn;
   endfunction

   assign fifoFull  = (fifoCount_q == CNT_MAX);
   assign fifoEmpty = (fifoCount_q == '0);

   // Next-state logic. A stalled pipeline freezes everything, so all work is
   // gated on stall being low. Whenever the pipeline does accept a slot and
   // nothing useful is issued, the slot is filled with a NOP marked invalid.
   // exec_dup is checked before the push so a request in the same cycle as a
   // candidate instruction wins and the instruction is discarded.
   always_comb begin
      phase_d     = phase_q;
      qedInst_d   = qedInst_q;
      qedValid_d  = qedValid_q;
      origCnt_d   = origCnt_q;
      dupCnt_d    = dupCnt_q;
      fifoCount_d = fifoCount_q;
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      pushEn      = 1'b0;

      if (!feedBus.stall) begin
         qedInst_d  = NOP;
         qedValid_d = 1'b0;
         case (phase_q)
            ORIG: begin
               if (feedBus.exec_dup) begin
                  if (origCnt_q != '0) begin
                     phase_d = DUP;
                  end
               end else if (fifoFull) begin
`ifdef QED_FORCE_DUP_EN
                  phase_d = DUP;
`else
                  phase_d = ORIG;
`endif
               end else begin
                  pushEn      = 1'b1;
                  qedInst_d   = feedBus.instruction;
                  qedValid_d  = 1'b1;
                  wrPtr_d     = wrPtr_q + PTR_W'(1);
                  fifoCount_d = fifoCount_q + CNT_W'(1);
                  if (origCnt_q != CNT_MAX) begin
                     origCnt_d = origCnt_q + CNT_W'(1);
                  end
               end
            end
            DUP: begin
               if (!fifoEmpty) begin
                  qedInst_d   = makeDup(origMem[rdPtr_q]);
                  qedValid_d  = 1'b1;
                  rdPtr_d     = rdPtr_q + PTR_W'(1);
                  fifoCount_d = fifoCount_q - CNT_W'(1);
                  if (dupCnt_q != CNT_MAX) begin
                     dupCnt_d = dupCnt_q + CNT_W'(1);
                  end
               end else begin
                  phase_d = DONE;
               end
            end
            default: begin
               // DONE and the unused encoding both just idle with NOPs
               phase_d = phase_q;
            end
         endcase
      end
   end

   // State register. Reset returns to an empty ORIG phase with a NOP on the
   // fetch port; buffer contents are left alone since the pointers and count
   // already mark it empty.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         phase_q     <= ORIG;
         qedInst_q   <= NOP;
         qedValid_q  <= 1'b0;
         origCnt_q   <= '0;
         dupCnt_q    <= '0;
         fifoCount_q <= '0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
      end else begin
         phase_q     <= phase_d;
         qedInst_q   <= qedInst_d;
         qedValid_q  <= qedValid_d;
         origCnt_q   <= origCnt_d;
         dupCnt_q    <= dupCnt_d;
         fifoCount_q <= fifoCount_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
      end
   end

   // Buffer storage has no reset so it can map onto plain memory
   always_ff @(posedge clk) begin
      if (pushEn) begin
         origMem[wrPtr_q] <= feedBus.instruction;
      end
   end

   assign feedBus.qed_inst  = qedInst_q;
   assign feedBus.qed_valid = qedValid_q;
   assign feedBus.orig_cnt  = origCnt_q;
   assign feedBus.dup_cnt   = dupCnt_q;
   assign feedBus.fifo_full = fifoFull;
   assign feedBus.phase     = phase_q;

   // Ready needs both halves to have run the same nonzero number of
   // instructions, and the encoding 3 counts as DONE
   assign feedBus.qed_ready = (phase_q != ORIG) && (phase_q != DUP) &&
                              (origCnt_q == dupCnt_q) && (origCnt_q != '0);

endmodule

// File: tb/tb_qed_dup_feeder.sv
// ---------------------------------------------------------------------------
// tb_qed_dup_feeder
// Drives qed_dup_feeder (DEPTH=4 so the full-buffer case is reachable) with
// directed scenarios and randomized episodes. A queue-based model of the
// feeder predicts every output each cycle; literal expectations in the
// directed scenarios pin the model to hand-computed values.
// Honors QED_FORCE_DUP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_qed_dup_feeder;

   localparam int INSN_LEN   = 32;
   localparam int DEPTH      = 4;
   localparam int REG_OFFSET = 16;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   logic reset_x = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   checkEn = 1'b0;

   qed_dup_feeder_if #(.INSN_LEN(INSN_LEN), .DEPTH(DEPTH)) feedBus ();

   qed_dup_feeder #(
      .INSN_LEN(INSN_LEN),
      .DEPTH(DEPTH),
      .REG_OFFSET(REG_OFFSET)
   ) dut (
      .clk(clk),
      .reset_x(reset_x),
      .feedBus(feedBus)
   );

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   // Shared comparison helper for both literal and model checks
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model of the duplicate rule: each 5-bit register slot that is nonzero
   // is shifted up by REG_OFFSET modulo 32
   function automatic logic [31:0] modelDup(input logic [31:0] insn);
      int slotPos [3] = '{7, 15, 20};
      logic [31:0] res;
      int idx;
      res = insn;
      for (int k = 0; k < 3; k++) begin
         idx = int'((insn >> slotPos[k]) & 32'h1F);
         if (idx != 0) begin
            idx = (idx + REG_OFFSET) % 32;
            res = (res & ~(32'h1F << slotPos[k])) | (32'(idx) << slotPos[k]);
         end
      end
      return res;
   endfunction

   // Behavioural model: a queue of originals plus counts and a phase number
   logic [31:0] mq [$];
   int          mOrig  = 0;
   int          mDup   = 0;
   int          mPhase = 0;
   logic [31:0] mInst  = NOP;
   logic        mValid = 1'b0;

   // Model update, evaluated on the same edges the design reacts to
   always @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         mq.delete();
         mOrig  = 0;
         mDup   = 0;
         mPhase = 0;
         mInst  = NOP;
         mValid = 1'b0;
      end else if (!feedBus.stall) begin
         mInst  = NOP;
         mValid = 1'b0;
         if (mPhase == 0) begin
            if (feedBus.exec_dup) begin
               if (mOrig > 0) mPhase = 1;
            end else if (mq.size() == DEPTH) begin
`ifdef QED_FORCE_DUP_EN
               mPhase = 1;
`endif
            end else begin
               mq.push_back(feedBus.instruction);
               mInst  = feedBus.instruction;
               mValid = 1'b1;
               mOrig++;
            end
         end else if (mPhase == 1) begin
            if (mq.size() > 0) begin
               mInst  = modelDup(mq.pop_front());
               mValid = 1'b1;
               mDup++;
            end else begin
               mPhase = 2;
            end
         end
      end
   end

   // Compare every output against the model each cycle, away from the edge
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("cmp_qed_inst", feedBus.qed_inst, mInst);
         checkOutput("cmp_qed_valid", 32'(feedBus.qed_valid), 32'(mValid));
         checkOutput("cmp_orig_cnt", 32'(feedBus.orig_cnt), 32'(mOrig));
         checkOutput("cmp_dup_cnt", 32'(feedBus.dup_cnt), 32'(mDup));
         checkOutput("cmp_phase", 32'(feedBus.phase), 32'(mPhase));
         checkOutput("cmp_fifo_full", 32'(feedBus.fifo_full), 32'(mq.size() == DEPTH));
         checkOutput("cmp_qed_ready", 32'(feedBus.qed_ready),
                     32'(mPhase == 2 && mOrig == mDup && mOrig != 0));
      end
   end

   // One clock of stimulus; returns 1 time unit after the rising edge
   task automatic applyStimulus(input logic [31:0] insn, input logic ex, input logic st);
      feedBus.instruction = insn;
      feedBus.exec_dup    = ex;
      feedBus.stall       = st;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      feedBus.instruction = 32'h0;
      feedBus.exec_dup    = 1'b0;
      feedBus.stall       = 1'b0;
      reset_x = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_x = 1'b1;
   endtask

   initial begin
      feedBus.instruction = 32'h0;
      feedBus.exec_dup    = 1'b0;
      feedBus.stall       = 1'b0;
      #2;
      doReset();
      checkEn = 1'b1;

      // Reset state
      checkOutput("rst_qed_inst", feedBus.qed_inst, NOP);
      checkOutput("rst_qed_valid", 32'(feedBus.qed_valid), 32'd0);
      checkOutput("rst_phase", 32'(feedBus.phase), 32'd0);
      checkOutput("rst_orig_cnt", 32'(feedBus.orig_cnt), 32'd0);
      checkOutput("rst_fifo_full", 32'(feedBus.fifo_full), 32'd0);
      checkOutput("rst_qed_ready", 32'(feedBus.qed_ready), 32'd0);

      // exec_dup with nothing issued stays in ORIG
      applyStimulus(32'h002081B3, 1'b1, 1'b0);
      checkOutput("empty_exec_phase", 32'(feedBus.phase), 32'd0);
      checkOutput("empty_exec_ready", 32'(feedBus.qed_ready), 32'd0);
      checkOutput("empty_exec_orig", 32'(feedBus.orig_cnt), 32'd0);

      // Basic ADD x3,x1,x2 and its duplicate ADD x19,x17,x18
      applyStimulus(32'h002081B3, 1'b0, 1'b0);
      checkOutput("basic_orig_inst", feedBus.qed_inst, 32'h002081B3);
      checkOutput("basic_orig_valid", 32'(feedBus.qed_valid), 32'd1);
      applyStimulus(32'hDEADBEEF, 1'b1, 1'b0);
      checkOutput("basic_exec_inst", feedBus.qed_inst, NOP);
      checkOutput("basic_exec_phase", 32'(feedBus.phase), 32'd1);
      applyStimulus(32'hDEADBEEF, 1'b0, 1'b0);
      checkOutput("basic_dup_inst", feedBus.qed_inst, 32'h012889B3);
      checkOutput("basic_dup_cnt", 32'(feedBus.dup_cnt), 32'd1);
      applyStimulus(32'hDEADBEEF, 1'b0, 1'b0);
      checkOutput("basic_done_phase", 32'(feedBus.phase), 32'd2);
      checkOutput("basic_ready", 32'(feedBus.qed_ready), 32'd1);
      applyStimulus(32'h00000000, 1'b1, 1'b0);
      checkOutput("basic_done_hold", 32'(feedBus.phase), 32'd2);

      // x0 fields stay zero; the immediate bits in the rs2 slot still move
      doReset();
      applyStimulus(32'h00500013, 1'b0, 1'b0);
      applyStimulus(32'h00000000, 1'b1, 1'b0);
      applyStimulus(32'h00000000, 1'b0, 1'b0);
      checkOutput("x0_dup_inst", feedBus.qed_inst, 32'h01500013);

      // Stall holds outputs and rejects the instruction offered meanwhile
      doReset();
      applyStimulus(32'h002081B3, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'h40B50533, 1'b1, 1'b1);
         checkOutput("stall_inst", feedBus.qed_inst, 32'h002081B3);
         checkOutput("stall_orig", 32'(feedBus.orig_cnt), 32'd1);
         checkOutput("stall_phase", 32'(feedBus.phase), 32'd0);
      end
      applyStimulus(32'h00000033, 1'b0, 1'b0);
      checkOutput("stall_after_orig", 32'(feedBus.orig_cnt), 32'd2);
      applyStimulus(32'h0, 1'b1, 1'b0);
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("stall_dup_first", feedBus.qed_inst, 32'h012889B3);

      // Full buffer: five offers into a depth-4 buffer
      doReset();
      applyStimulus(32'h002081B3, 1'b0, 1'b0);
      applyStimulus(32'h00500013, 1'b0, 1'b0);
      applyStimulus(32'h00000033, 1'b0, 1'b0);
      applyStimulus(32'h40B50533, 1'b0, 1'b0);
      checkOutput("full_flag", 32'(feedBus.fifo_full), 32'd1);
      applyStimulus(32'hFFFFFFFF, 1'b0, 1'b0);
      checkOutput("full_orig", 32'(feedBus.orig_cnt), 32'd4);
      checkOutput("full_valid", 32'(feedBus.qed_valid), 32'd0);
`ifdef QED_FORCE_DUP_EN
      checkOutput("full_phase", 32'(feedBus.phase), 32'd1);
`else
      checkOutput("full_phase", 32'(feedBus.phase), 32'd0);
      applyStimulus(32'h0, 1'b1, 1'b0);
`endif
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("full_dup0", feedBus.qed_inst, 32'h012889B3);
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("full_dup1", feedBus.qed_inst, 32'h01500013);
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("full_dup2", feedBus.qed_inst, 32'h00000033);
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("full_dup3", feedBus.qed_inst, 32'h41BD0D33);
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("full_ready", 32'(feedBus.qed_ready), 32'd1);

      // Asynchronous reset in the middle of DUP with three duplicates issued
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(32'h002081B3 + 32'(i << 7), 1'b0, 1'b0);
      applyStimulus(32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("midrst_pre_dup", 32'(feedBus.dup_cnt), 32'd3);
      #2;
      reset_x = 1'b0;
      #1;
      checkOutput("midrst_phase", 32'(feedBus.phase), 32'd0);
      checkOutput("midrst_orig", 32'(feedBus.orig_cnt), 32'd0);
      checkOutput("midrst_dup", 32'(feedBus.dup_cnt), 32'd0);
      checkOutput("midrst_inst", feedBus.qed_inst, NOP);
      checkOutput("midrst_valid", 32'(feedBus.qed_valid), 32'd0);
      @(posedge clk);
      #1;
      reset_x = 1'b1;

      // Randomized episodes checked by the model every cycle
      for (int ep = 0; ep < 25; ep++) begin
         doReset();
         for (int c = 0; c < 40; c++) begin
            applyStimulus($urandom, ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
         end
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
